// File: rtl/led_mode_scheduler.sv
// Debounced button steps OFF/SLOW/FAST/CHASE; LED bank blinks or chases on a wrapping period counter.
// Latency: key_n edge to press is 2+DEBOUNCE_CYC cycles, LED/mode one cycle later; no backpressure.
module led_mode_scheduler #(
    parameter int N_LED        = 8,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SLOW_HALF    = 25_000_000,
    parameter int FAST_HALF    = 6_250_000
) (
    input  logic             FPGA_CLK1_50,
    input  logic             rst,
    input  logic             key_n,
    output logic [N_LED-1:0] LED,
    output logic [1:0]       mode,
    output logic             tick
);

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_SLOW  = 2'd1,
        M_FAST  = 2'd2,
        M_CHASE = 2'd3
    } mode_t;

    localparam int               DB_W      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [31:0]      SLOW_LAST = 32'(SLOW_HALF - 1);
    localparam logic [31:0]      FAST_LAST = 32'(FAST_HALF - 1);
    localparam logic [N_LED-1:0] PTR_INIT  = N_LED'(1);

    logic            sync1, sync2;
    logic            key_stable;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge FPGA_CLK1_50) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            key_stable <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != key_stable) begin
                if (db_cnt == DB_LAST) begin
                    key_stable <= sync2;
                    db_cnt     <= '0;
                    // only the 1->0 transition of the stable key is a press
                    press      <= key_stable;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    mode_t            mode_q, mode_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [N_LED-1:0] ptr_q, ptr_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [1:0]       mode_inc;
    logic [31:0]      half_last;
    logic             at_wrap;
    logic             tick_c;

    always_ff @(posedge FPGA_CLK1_50) begin
        if (rst) begin
            mode_q  <= M_OFF;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            ptr_q   <= PTR_INIT;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        ptr_d     = ptr_q;
        led_d     = '0;
        tick_c    = 1'b0;
        mode_inc  = mode_q + 2'd1;
        half_last = (mode_q == M_FAST) ? FAST_LAST : SLOW_LAST;
        at_wrap   = (cnt_q == half_last);

        if (mode_q != M_OFF) begin
            tick_c = at_wrap;
        end

        // a press overrides a coinciding wrap: the new mode starts from a clean phase
        if (press) begin
            mode_d  = mode_t'(mode_inc);
            cnt_d   = '0;
            phase_d = 1'b1;
            ptr_d   = PTR_INIT;
        end else if (mode_q == M_OFF) begin
            cnt_d = '0;
        end else if (at_wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            ptr_d   = {ptr_q[N_LED-2:0], ptr_q[N_LED-1]};
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        case (mode_d)
            M_OFF:   led_d = '0;
            M_CHASE: led_d = ptr_d;
            default: led_d = {N_LED{phase_d}};
        endcase
    end

    assign LED  = led_q;
    assign mode = mode_q;
    assign tick = tick_c;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench: per-cycle expectations derived from mode-entry timing are queued at drive time
// and popped against LED/mode/tick sampled on the falling edge.
module tb_led_mode_scheduler;

    logic       clk;
    logic       rst;
    logic       key_n;
    logic [3:0] LED;
    logic [1:0] mode;
    logic       tick;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] led;
        logic       tick;
    } exp_t;

    exp_t       exp_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [1:0] cur_mode   = 2'd0;
    int         mk         = 0;

    led_mode_scheduler #(
        .N_LED       (4),
        .DEBOUNCE_CYC(4),
        .SLOW_HALF   (8),
        .FAST_HALF   (2)
    ) dut (
        .FPGA_CLK1_50(clk),
        .rst         (rst),
        .key_n       (key_n),
        .LED         (LED),
        .mode        (mode),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs expected k cycles after entering mode m.
    function automatic exp_t model(input logic [1:0] m, input int k);
        exp_t e;
        int   half;
        e.mode = m;
        e.led  = 4'h0;
        e.tick = 1'b0;
        half   = (m == 2'd2) ? 2 : 8;
        if (m != 2'd0) begin
            e.tick = ((k % half) == half - 1);
            if (m == 2'd3) e.led = 4'b0001 << ((k / half) % 4);
            else           e.led = (((k / half) % 2) == 0) ? 4'hF : 4'h0;
        end
        return e;
    endfunction

    task automatic step(input logic k, input logic r);
        @(posedge clk);
        #1;
        key_n = k;
        rst   = r;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) step(1'b1, 1'b1);
        cur_mode = 2'd0;
        mk       = 0;
        for (int c = 0; c < 50; c++) begin
            step(1'b1, 1'b0);
            exp_q.push_back(model(cur_mode, mk));
            mk++;
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (mode !== e.mode || LED !== e.led || tick !== e.tick) begin
                mismatched++;
                $display("FAIL reset c=%0d: got mode=%0d LED=%h tick=%b, want mode=%0d LED=%h tick=%b",
                         c, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            step((c < 3) ? 1'b0 : 1'b1, 1'b0);
            exp_q.push_back(model(cur_mode, mk));
            mk++;
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (mode !== e.mode || LED !== e.led || tick !== e.tick) begin
                mismatched++;
                $display("FAIL glitch c=%0d: got mode=%0d LED=%h tick=%b, want mode=%0d LED=%h tick=%b",
                         c, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    endtask

    // Key low for `low` cycles from c=0; the new mode is visible 7 cycles after the key edge.
    task automatic test_press(input string name, input int low, input int total, input logic [1:0] new_mode);
        exp_t e;
        for (int c = 0; c < total; c++) begin
            step((c < low) ? 1'b0 : 1'b1, 1'b0);
            if (c == 7) begin
                cur_mode = new_mode;
                mk       = 0;
            end
            exp_q.push_back(model(cur_mode, mk));
            mk++;
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (mode !== e.mode || LED !== e.led || tick !== e.tick) begin
                mismatched++;
                $display("FAIL %s c=%0d: got mode=%0d LED=%h tick=%b, want mode=%0d LED=%h tick=%b",
                         name, c, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    endtask

    // Entered with CHASE at mk=40: LED=4'h4 at c=10, where rst is pulsed with the key already low.
    task automatic test_rst_mid();
        exp_t e;
        for (int c = 0; c < 32; c++) begin
            step((c < 8) ? 1'b1 : 1'b0, (c == 10));
            if (c == 11) begin
                cur_mode = 2'd0;
                mk       = 0;
            end
            if (c == 18) begin
                cur_mode = 2'd1;
                mk       = 0;
            end
            exp_q.push_back(model(cur_mode, mk));
            mk++;
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (c == 10 && LED !== 4'h4) begin
                mismatched++;
                $display("FAIL rst_mid_setup: got LED=%h, want LED=4", LED);
            end
            if (mode !== e.mode || LED !== e.led || tick !== e.tick) begin
                mismatched++;
                $display("FAIL rst_mid c=%0d: got mode=%0d LED=%h tick=%b, want mode=%0d LED=%h tick=%b",
                         c, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    endtask

    // Release, then three 8-low/8-high presses: SLOW -> FAST -> CHASE -> OFF.
    task automatic test_back_to_back();
        exp_t e;
        int   b;
        int   p;
        for (int c = 0; c < 8 + 3 * 16 + 12; c++) begin
            b = (c - 8) / 16;
            p = (c - 8) % 16;
            step((c >= 8 && b < 3 && p < 8) ? 1'b0 : 1'b1, 1'b0);
            if (c >= 8 && b < 3 && p == 7) begin
                cur_mode = cur_mode + 2'd1;
                mk       = 0;
            end
            exp_q.push_back(model(cur_mode, mk));
            mk++;
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (mode !== e.mode || LED !== e.led || tick !== e.tick) begin
                mismatched++;
                $display("FAIL back_to_back c=%0d: got mode=%0d LED=%h tick=%b, want mode=%0d LED=%h tick=%b",
                         c, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 1'b1;
        test_reset();
        test_glitch();
        test_press("press_slow", 20, 60, 2'd1);
        test_press("press_fast", 6, 30, 2'd2);
        test_press("press_chase", 6, 47, 2'd3);
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
